data_memory_ctrl: RTL and testbench
===================================

# data_memory_ctrl

Parametrised data-memory controller for the CPU's load/store path, replacing the fixed single-cycle data RAM. It supports byte, halfword and word accesses with sign or zero extension on loads, detects misaligned accesses, and has a configurable access latency with a busy/response handshake so multi-cycle and pipelined cores can stall on it. Storage is internal: four byte lanes of `DEPTH_WORDS` entries.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: byte-address width.
- `DEPTH_WORDS`, default 1024: number of 32-bit words; must be a power of two and at least 4.
- `LATENCY`, default 1: cycles from request acceptance to response; legal range 1..8.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `MemREAD`  in  1: load request.
- `MemWrite`  in  2: store request and size. 00 none, 01 byte, 10 half, 11 word.
- `load_size`  in  2: load size. 01 byte, 10 half, 11 word; 00 is treated as word.
- `load_unsigned`  in  1: 1 zero-extends loads, 0 sign-extends them.
- `address`  in  ADDR_WIDTH: byte address.
- `write_data`  in  32: store data, right-aligned.
- `read_data`  out  32: extended load result; valid while `resp_valid` is high.
- `resp_valid`  out  1: one-cycle completion pulse, for loads and stores alike.
- `busy`  out  1: controller cannot accept a request this cycle.
- `misaligned`  out  1: qualifies `resp_valid`; the access was rejected.
- `parity_err`  out  1: qualifies `resp_valid`; see Configuration.

## Operation
- **Request.** A request is `MemREAD=1` or `MemWrite!=00`.
  - It is accepted at a rising edge where it is present and `busy=0`.
  - Requests presented while `busy=1` are ignored, not queued. The core must hold them.
  - On acceptance the controller latches address, data, size and sign mode. The inputs may change afterwards.
- **Simultaneous read and write.** The store wins and the load is dropped. Only one response is produced.
- **State machine.**
  - IDLE: `busy=0`. On accept with `LATENCY=1`, the access happens at the accept edge and the controller stays in IDLE. On accept with `LATENCY>1`, load the counter with `LATENCY-1` and go to WAIT.
  - WAIT: `busy=1`. The counter decrements each edge. The access happens at the edge where the counter goes from 1 to 0, and the controller returns to IDLE at that edge.
- **Access.**
  - Word index is `address[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo `4*DEPTH_WORDS`.
  - Stores write only the addressed lanes:
    - byte: `write_data[7:0]` goes to lane `address[1:0]`.
    - half: `write_data[15:0]` goes to lanes `{address[1],0}` and `{address[1],1}`.
    - word: all four lanes are written.
  - Loads select the addressed byte or half and extend it to 32 bits according to `load_unsigned`.
  - Lane order is little-endian.
- **Misalignment.** A half access with `address[0]=1`, or a word access with `address[1:0]!=0`, performs no memory access. It still completes after `LATENCY` cycles, with `misaligned=1` and `read_data=0`.
- **Reset.**
  - Reset returns the controller to IDLE and clears the counter. Any pending access is discarded; a store in WAIT is never committed.
  - Reset does not clear memory contents.

## Timing
- Reset values: `read_data=0`, `resp_valid=0`, `busy=0`, `misaligned=0`, `parity_err=0`.
- Request accepted at edge E0:
  - The access occurs at edge E0+LATENCY-1.
  - `resp_valid`, `read_data`, `misaligned` and `parity_err` are registered. They are valid in the cycle after that edge, for exactly one cycle.
  - Between responses `read_data` returns to 0.
- `busy` is high in the cycles after E0 up to and including the cycle before the access edge. It is low in the response cycle, so a new request may be accepted in the same cycle `resp_valid` is high.
- `LATENCY=1` gives one access per cycle and `busy` is never asserted. Throughput is one access per `LATENCY` cycles.
- A load issued right after a store to the same word sees the stored data, because the store commits before the load's access edge.

## Configuration
- Macro: `DMEM_PARITY_EN`.
- Defined:
  - One even-parity bit is stored per byte lane, written with the lane.
  - On loads, every lane touched is checked. Any mismatch sets `parity_err=1` with `resp_valid`; the data is still returned.
  - Stores and misaligned accesses report `parity_err=0`.
  - Parity RAM content is not reset, so a load from an unwritten location may flag an error.
- Not defined: no parity storage is built and `parity_err` is tied to 0.

## Test plan
- Reset values, `LATENCY=1`: after `rst`, all outputs read 0. Store word `0xDEADBEEF` at `0x10`, then load word from `0x10` on the next cycle → `resp_valid` one cycle after each accept, load `read_data=0xDEADBEEF`, `busy` never high.
- Byte/half lanes and extension: store word `0x11223344` at `0x20`.
  - Store byte `0x80` at `0x21`, then load word → `0x11228044`.
  - Load byte signed at `0x21` → `0xFFFFFF80`; load byte unsigned → `0x00000080`.
  - Load half signed at `0x22` → `0x00001122`.
- Latency and stall, `LATENCY=3`: load accepted at E0 → `busy` high for 2 cycles and `resp_valid` in cycle E0+3. A second request held during `busy` is accepted only in the response cycle.
- Misalignment: word load at `0x06` and half store at `0x03` → `misaligned=1`, `read_data=0`, and a following word load at `0x04` shows memory unchanged.
- Simultaneous and wrap: assert `MemREAD=1` with `MemWrite=11` at address `4*DEPTH_WORDS+8` → a single response, and a later load from `0x08` returns the stored data.
- Reset mid-operation, `LATENCY=4`: accept a store, assert `rst` in WAIT → no `resp_valid`, and a load returns the old value. With `DMEM_PARITY_EN`, corrupt a parity bit via hierarchical force → load reports `parity_err=1`.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// Load/store data-memory controller: four internal byte lanes, sized/extended loads, misalignment
// reporting, LATENCY-cycle busy/response handshake. Optional lane parity via DMEM_PARITY_EN.
//
// state  | meaning
// S_IDLE | ready; with LATENCY=1 the access happens at the accept edge
// S_WAIT | request latched, down-counter running; access at the 1->0 count edge
module data_memory_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemREAD,
    input  logic [1:0]            MemWrite,
    input  logic [1:0]            load_size,
    input  logic                  load_unsigned,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           write_data,
    output logic [31:0]           read_data,
    output logic                  resp_valid,
    output logic                  busy,
    output logic                  misaligned,
    output logic                  parity_err
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           state;
    logic [2:0]       cnt;
    logic             req_store;
    logic [1:0]       req_size;
    logic             req_uns;
    logic [IDX_W+1:0] req_addr;
    logic [31:0]      req_wdata;

    logic [7:0] mem [DEPTH_WORDS][4];

    logic             req, accept, acc_fire, acc_store, acc_uns, acc_mis, par_bad;
    logic [1:0]       acc_size, acc_lane;
    logic [IDX_W+1:0] acc_addr;
    logic [IDX_W-1:0] acc_idx;
    logic [31:0]      acc_wdata, ld_data;
    logic [3:0]       lane_en;
    logic [7:0]       lane_wd [4];
    logic [7:0]       rd_lane [4];
    logic [15:0]      rd_half;

    // A store always takes priority; an unsized load means word.
    function automatic logic [1:0] eff_size(input logic [1:0] wr, input logic [1:0] ls);
        if (wr != 2'b00) return wr;
        return (ls == 2'b00) ? 2'b11 : ls;
    endfunction

    generate
        if (ADDR_WIDTH > IDX_W + 2) begin : g_wrap
            logic unused_upper_addr;
            assign unused_upper_addr = ^address[ADDR_WIDTH-1:IDX_W+2];
        end
    endgenerate

    assign req    = MemREAD | (MemWrite != 2'b00);
    assign accept = req & ~busy & ~rst;

    // With LATENCY=1 the access is served straight from the request inputs.
    always_comb begin
        if (LATENCY == 1) begin
            acc_fire  = accept;
            acc_store = (MemWrite != 2'b00);
            acc_size  = eff_size(MemWrite, load_size);
            acc_uns   = load_unsigned;
            acc_addr  = address[IDX_W+1:0];
            acc_wdata = write_data;
        end else begin
            acc_fire  = (state == S_WAIT) && (cnt == 3'd1) && !rst;
            acc_store = req_store;
            acc_size  = req_size;
            acc_uns   = req_uns;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end
    end

    assign acc_idx  = acc_addr[IDX_W+1:2];
    assign acc_lane = acc_addr[1:0];
    assign acc_mis  = ((acc_size == 2'b10) && acc_addr[0]) ||
                      ((acc_size == 2'b11) && (acc_addr[1:0] != 2'b00));

    always_comb begin
        lane_en = 4'b0000;
        case (acc_size)
            2'b01:   lane_en[acc_lane] = 1'b1;
            2'b10:   lane_en = acc_lane[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
        for (int l = 0; l < 4; l++) begin
            rd_lane[l] = mem[acc_idx][l];
            case (acc_size)
                2'b01:   lane_wd[l] = acc_wdata[7:0];
                2'b10:   lane_wd[l] = acc_wdata[8*(l%2) +: 8];
                default: lane_wd[l] = acc_wdata[8*l +: 8];
            endcase
        end
    end

    always_comb begin
        rd_half = acc_lane[1] ? {rd_lane[3], rd_lane[2]} : {rd_lane[1], rd_lane[0]};
        case (acc_size)
            2'b01:   ld_data = {{24{~acc_uns & rd_lane[acc_lane][7]}}, rd_lane[acc_lane]};
            2'b10:   ld_data = {{16{~acc_uns & rd_half[15]}}, rd_half};
            default: ld_data = {rd_lane[3], rd_lane[2], rd_lane[1], rd_lane[0]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (acc_fire && acc_store && !acc_mis)
            for (int l = 0; l < 4; l++)
                if (lane_en[l]) mem[acc_idx][l] <= lane_wd[l];
    end

`ifdef DMEM_PARITY_EN
    logic [3:0] par_mem [DEPTH_WORDS];
    logic [3:0] par_chk;

    always_ff @(posedge clk) begin
        if (acc_fire && acc_store && !acc_mis)
            for (int l = 0; l < 4; l++)
                if (lane_en[l]) par_mem[acc_idx][l] <= ^lane_wd[l];
    end

    always_comb begin
        par_chk = 4'b0000;
        for (int l = 0; l < 4; l++)
            par_chk[l] = (^rd_lane[l]) ^ par_mem[acc_idx][l];
        par_bad = |(par_chk & lane_en);
    end
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 3'd0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            read_data  <= 32'd0;
            misaligned <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            resp_valid <= acc_fire;
            misaligned <= acc_fire && acc_mis;
            read_data  <= (acc_fire && !acc_store && !acc_mis) ? ld_data : 32'd0;
            parity_err <= acc_fire && !acc_store && !acc_mis && par_bad;
            case (state)
                S_IDLE: begin
                    if (accept && (LATENCY > 1)) begin
                        req_store <= (MemWrite != 2'b00);
                        req_size  <= eff_size(MemWrite, load_size);
                        req_uns   <= load_unsigned;
                        req_addr  <= address[IDX_W+1:0];
                        req_wdata <= write_data;
                        cnt       <= 3'(LATENCY - 1);
                        state     <= S_WAIT;
                        busy      <= 1'b1;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: three instances (LATENCY 1, 3, 4) behind one request bus, checked
// against a byte-array reference model. Parity checks build only with DMEM_PARITY_EN.
module tb_data_memory_ctrl;
    localparam int DW = 16;
    localparam int NB = 4 * DW;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic [1:0]  mem_write, load_size;
    logic        load_unsigned;
    logic [31:0] address, write_data;
    logic [1:0]  sel;
    logic [2:0]  en;

    logic [31:0] rdata [3];
    logic        rv [3];
    logic        bsy [3];
    logic        mis [3];
    logic        perr [3];

    logic [31:0] o_rdata;
    logic        o_rv, o_bsy, o_mis, o_perr;

    logic [7:0]  mdl [3][NB];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          exp_perr_flag = 1'b0;

    always #5 clk = ~clk;

    assign en = 3'b001 << sel;

    data_memory_ctrl #(.ADDR_WIDTH(32), .DEPTH_WORDS(DW), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .MemREAD(mem_read & en[0]), .MemWrite(mem_write & {2{en[0]}}),
        .load_size(load_size), .load_unsigned(load_unsigned), .address(address),
        .write_data(write_data), .read_data(rdata[0]), .resp_valid(rv[0]), .busy(bsy[0]),
        .misaligned(mis[0]), .parity_err(perr[0]));

    data_memory_ctrl #(.ADDR_WIDTH(32), .DEPTH_WORDS(DW), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .MemREAD(mem_read & en[1]), .MemWrite(mem_write & {2{en[1]}}),
        .load_size(load_size), .load_unsigned(load_unsigned), .address(address),
        .write_data(write_data), .read_data(rdata[1]), .resp_valid(rv[1]), .busy(bsy[1]),
        .misaligned(mis[1]), .parity_err(perr[1]));

    data_memory_ctrl #(.ADDR_WIDTH(32), .DEPTH_WORDS(DW), .LATENCY(4)) dut4 (
        .clk(clk), .rst(rst), .MemREAD(mem_read & en[2]), .MemWrite(mem_write & {2{en[2]}}),
        .load_size(load_size), .load_unsigned(load_unsigned), .address(address),
        .write_data(write_data), .read_data(rdata[2]), .resp_valid(rv[2]), .busy(bsy[2]),
        .misaligned(mis[2]), .parity_err(perr[2]));

    always_comb begin
        case (sel)
            2'd1:    begin o_rdata = rdata[1]; o_rv = rv[1]; o_bsy = bsy[1]; o_mis = mis[1]; o_perr = perr[1]; end
            2'd2:    begin o_rdata = rdata[2]; o_rv = rv[2]; o_bsy = bsy[2]; o_mis = mis[2]; o_perr = perr[2]; end
            default: begin o_rdata = rdata[0]; o_rv = rv[0]; o_bsy = bsy[0]; o_mis = mis[0]; o_perr = perr[0]; end
        endcase
    end

    function automatic int lat_of(input logic [1:0] s);
        return (s == 2'd0) ? 1 : ((s == 2'd1) ? 3 : 4);
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: memory as a flat little-endian byte array; accesses wrap modulo its size.
    task automatic model_access(input int d, input bit rd, input logic [1:0] wr, input logic [1:0] lsz,
                                input bit uns, input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] exp_rd, output bit exp_mis, output bit is_store);
        int nbytes, off;
        logic [63:0] v;
        is_store = (wr != 2'b00);
        if (is_store) nbytes = (wr == 2'd1) ? 1 : ((wr == 2'd2) ? 2 : 4);
        else          nbytes = (lsz == 2'd1) ? 1 : ((lsz == 2'd2) ? 2 : 4);
        off     = int'(addr % 32'(NB));
        exp_mis = (off % nbytes) != 0;
        exp_rd  = 32'd0;
        if (!rd && !is_store) return;
        if (exp_mis) return;
        if (is_store) begin
            for (int i = 0; i < nbytes; i++) mdl[d][off+i] = wd[8*i +: 8];
        end else begin
            v = 64'd0;
            for (int i = 0; i < nbytes; i++) v = v | (64'(mdl[d][off+i]) << (8*i));
            if (!uns && v[8*nbytes-1]) v = v | ~((64'd1 << (8*nbytes)) - 64'd1);
            exp_rd = v[31:0];
        end
    endtask

    task automatic clear_req();
        mem_read   = 1'b0;
        mem_write  = 2'b00;
        address    = $urandom;
        write_data = $urandom;
    endtask

    // Present a request, hold it until accepted, then check timing and result against the model.
    task automatic do_access(input string tag, input bit rd, input logic [1:0] wr, input logic [1:0] lsz,
                             input bit uns, input logic [31:0] addr, input logic [31:0] wd,
                             output logic [31:0] obs);
        logic [31:0] exp_rd;
        bit exp_mis, is_store;
        int k, lat;
        lat = lat_of(sel);
        model_access(int'(sel), rd, wr, lsz, uns, addr, wd, exp_rd, exp_mis, is_store);
        mem_read = rd; mem_write = wr; load_size = lsz; load_unsigned = uns;
        address = addr; write_data = wd;
        k = 0;
        while (o_bsy && k < 20) begin @(posedge clk); #1; k++; end
        check32({tag, "_accept_bound"}, 32'(k < 20), 32'd1);
        @(posedge clk); #1;
        clear_req();
        k = 0;
        while (!o_rv && k < 12) begin
            check32({tag, "_busy_wait"}, 32'(o_bsy), 32'(lat > 1));
            @(posedge clk); #1; k++;
        end
        check32({tag, "_latency"}, 32'(k), 32'(lat - 1));
        check32({tag, "_mis"}, 32'(o_mis), 32'(exp_mis));
        check32({tag, "_perr"}, 32'(o_perr), 32'(exp_perr_flag && !is_store && !exp_mis));
        check32({tag, "_busy_resp"}, 32'(o_bsy), 32'd0);
        if (!is_store || exp_mis) check32({tag, "_rdata"}, o_rdata, exp_rd);
        obs = o_rdata;
    endtask

    logic [31:0] obs;
    bit exp_rv_tab [6] = '{0, 0, 1, 0, 0, 1};
    bit exp_bsy_tab [6] = '{1, 1, 0, 1, 1, 0};

    initial begin
        sel = 2'd0;
        rst = 1'b1;
        load_size = 2'b11;
        load_unsigned = 1'b0;
        clear_req();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check32("rst_rdata", rdata[d], 32'd0);
            check32("rst_rv", 32'(rv[d]), 32'd0);
            check32("rst_busy", 32'(bsy[d]), 32'd0);
            check32("rst_mis", 32'(mis[d]), 32'd0);
            check32("rst_perr", 32'(perr[d]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // LATENCY=1 basics, lanes and extension
        sel = 2'd0;
        do_access("st_w10", 0, 2'b11, 2'b11, 0, 32'h10, 32'hDEADBEEF, obs);
        do_access("ld_w10", 1, 2'b00, 2'b11, 0, 32'h10, 32'h0, obs);
        check32("ld_w10_const", obs, 32'hDEADBEEF);
        do_access("st_w20", 0, 2'b11, 2'b11, 0, 32'h20, 32'h11223344, obs);
        do_access("st_b21", 0, 2'b01, 2'b11, 0, 32'h21, 32'h00000080, obs);
        do_access("ld_w20", 1, 2'b00, 2'b00, 0, 32'h20, 32'h0, obs);
        check32("ld_w20_const", obs, 32'h11228044);
        do_access("ld_bs21", 1, 2'b00, 2'b01, 0, 32'h21, 32'h0, obs);
        check32("ld_bs21_const", obs, 32'hFFFFFF80);
        do_access("ld_bu21", 1, 2'b00, 2'b01, 1, 32'h21, 32'h0, obs);
        check32("ld_bu21_const", obs, 32'h00000080);
        do_access("ld_hs22", 1, 2'b00, 2'b10, 0, 32'h22, 32'h0, obs);
        check32("ld_hs22_const", obs, 32'h00001122);

        // misalignment leaves memory untouched
        do_access("st_w04", 0, 2'b11, 2'b11, 0, 32'h04, 32'hCAFEF00D, obs);
        do_access("mis_ldw06", 1, 2'b00, 2'b11, 0, 32'h06, 32'h0, obs);
        check32("mis_ldw06_flag", 32'(o_mis), 32'd1);
        do_access("mis_sth03", 0, 2'b10, 2'b11, 0, 32'h03, 32'h0000BEEF, obs);
        check32("mis_sth03_flag", 32'(o_mis), 32'd1);
        do_access("ld_w04", 1, 2'b00, 2'b11, 0, 32'h04, 32'h0, obs);
        check32("ld_w04_const", obs, 32'hCAFEF00D);

        // simultaneous read+write with a wrapping address: one response, store wins
        do_access("rw_wrap", 1, 2'b11, 2'b11, 0, 32'(NB + 8), 32'h5A5A1234, obs);
        @(posedge clk); #1;
        check32("rw_single_rv", 32'(o_rv), 32'd0);
        check32("rw_rdata_idle", o_rdata, 32'd0);
        do_access("ld_w08", 1, 2'b00, 2'b11, 0, 32'h08, 32'h0, obs);
        check32("ld_w08_const", obs, 32'h5A5A1234);

        // LATENCY=3 stall: a request held during busy is taken in the response cycle
        sel = 2'd1;
        do_access("l3_st0c", 0, 2'b11, 2'b11, 0, 32'h0C, 32'h01020304, obs);
        mem_read = 1'b1; mem_write = 2'b00; load_size = 2'b11; load_unsigned = 1'b0; address = 32'h0C;
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 2'b11; address = 32'h0C; write_data = 32'hA5A5A5A5;
        for (int t = 0; t < 6; t++) begin
            check32($sformatf("l3_rv_t%0d", t), 32'(o_rv), 32'(exp_rv_tab[t]));
            check32($sformatf("l3_busy_t%0d", t), 32'(o_bsy), 32'(exp_bsy_tab[t]));
            if (t == 2) check32("l3_ld_data", o_rdata, 32'h01020304);
            if (t == 3) clear_req();
            if (t < 5) begin @(posedge clk); #1; end
        end
        for (int i = 0; i < 4; i++) mdl[1][12+i] = 8'hA5;
        do_access("l3_ld0c", 1, 2'b00, 2'b11, 0, 32'h0C, 32'h0, obs);
        check32("l3_ld0c_const", obs, 32'hA5A5A5A5);

        // LATENCY=4: reset in WAIT discards the pending store
        sel = 2'd2;
        do_access("l4_st30", 0, 2'b11, 2'b11, 0, 32'h30, 32'h0BADF00D, obs);
        mem_write = 2'b11; address = 32'h30; write_data = 32'hFFFFFFFF;
        @(posedge clk); #1;
        clear_req();
        @(posedge clk); #1;
        check32("l4_busy_wait", 32'(o_bsy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check32("l4_busy_after_rst", 32'(o_bsy), 32'd0);
        for (int t = 0; t < 4; t++) begin
            check32("l4_no_resp", 32'(o_rv), 32'd0);
            @(posedge clk); #1;
        end
        do_access("l4_ld30", 1, 2'b00, 2'b11, 0, 32'h30, 32'h0, obs);
        check32("l4_ld30_const", obs, 32'h0BADF00D);

`ifdef DMEM_PARITY_EN
        do_access("par_st3c", 0, 2'b11, 2'b11, 0, 32'h3C, 32'h12345678, obs);
        dut4.par_mem[15] = dut4.par_mem[15] ^ 4'b0010;
        exp_perr_flag = 1'b1;
        do_access("par_ld3c", 1, 2'b00, 2'b11, 0, 32'h3C, 32'h0, obs);
        exp_perr_flag = 1'b0;
        check32("par_ld3c_const", obs, 32'h12345678);
        do_access("par_st3c_fix", 0, 2'b11, 2'b11, 0, 32'h3C, 32'h12345678, obs);
`endif

        // randomized traffic on every latency
        for (int d = 0; d < 3; d++) begin
            sel = 2'(d);
            for (int w = 0; w < DW; w++)
                do_access("rnd_init", 0, 2'b11, 2'b11, 0, 32'(4*w), $urandom, obs);
            for (int n = 0; n < 40; n++) begin
                int op;
                logic [1:0] wr;
                op = $urandom_range(0, 3);
                wr = 2'($urandom_range(1, 3));
                do_access($sformatf("rnd_d%0d_n%0d", d, n), (op != 1), (op == 1 || op == 2) ? wr : 2'b00,
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom, obs);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
